// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side byte streams and the transmitter-side
//   start/data/busy handshake of uart_tx_arbiter into one interface.
//
//   Signals
//     req_valid     [NREQ]    per-requester byte valid
//     req_data      [8*NREQ]  byte of requester i in bits [8i+7:8i]
//     req_last      [NREQ]    final byte of a packet
//     req_ready     [NREQ]    byte accepted this cycle
//     tx_start                one-cycle pulse to TxD_start
//     tx_data       [8]       byte to TxD_data
//     tx_busy                 TxD_busy from the transmitter
//     grant         [NREQ]    one-hot current owner, zero when none
//     timeout_pulse           one-cycle flag on a timeout revoke
//
//   Modports
//     slave  : the arbiter itself
//     master : the surrounding producers and transmitter
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [NREQ-1:0]   grant;
  logic              timeout_pulse;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant, timeout_pulse
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one async transmitter between NREQ byte-stream requesters.
//   Arbitration is round-robin and packet-granular: an owner keeps the grant
//   from its first byte until the byte flagged last has left the
//   transmitter, so packets never interleave on TxD. An owner that leaves
//   req_valid low for TIMEOUT cycles while the arbiter waits for its next
//   byte loses the grant.
//
//   Ports
//     clk    : single clock
//     reset  : synchronous, active-high reset
//     bus    : uart_tx_arbiter_if.slave (requester streams, transmitter
//              handshake, grant and timeout_pulse)
//
//   Parameters
//     NREQ     : number of requesters (2..8)
//     TIMEOUT  : idle LOAD cycles before the grant is revoked, 0 = never
//     CNT_W    : timeout counter width, TIMEOUT < 2**CNT_W
//     HDR_BASE : header byte base value
//
//   Optional feature (macro UART_ARB_HDR_EN)
//     Each packet is preceded by a header byte HDR_BASE + owner index.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         TIMEOUT  = 1024,
  parameter int         CNT_W    = 16,
  parameter logic [7:0] HDR_BASE = 8'hF0
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // Counter value at which this idle cycle is the TIMEOUT-th one.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
`ifdef UART_ARB_HDR_EN
    HDR   = 3'd1,
`endif
    LOAD  = 3'd2,
    START = 3'd3,
    BUSY  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]  own_q,   own_d;     // index of the current owner
  logic [PTR_W-1:0]  ptr_q,   ptr_d;     // last served requester
  logic [7:0]        tx_data_q, tx_data_d;
  logic              last_q,  last_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              to_pulse_q, to_pulse_d;
  logic              first_q, first_d;   // first BUSY cycle, tx_busy not yet valid

  logic              pick_found;
  logic [PTR_W-1:0]  pick_idx;
  logic              own_valid;
  logic              own_last;
  logic [7:0]        own_data;

  assign own_valid = bus.req_valid[own_q];
  assign own_last  = bus.req_last[own_q];
  assign own_data  = bus.req_data[{own_q, 3'b000} +: 8];

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    own_d      = own_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    cnt_d      = (state_q == LOAD) ? cnt_q : '0;
    to_pulse_d = 1'b0;
    first_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          own_d             = pick_idx;
`ifdef UART_ARB_HDR_EN
          state_d           = HDR;
`else
          state_d           = LOAD;
`endif
        end
      end

`ifdef UART_ARB_HDR_EN
      // Wait for an in-flight byte (e.g. one left over from a reset) first.
      HDR: begin
        if (!bus.tx_busy) begin
          tx_data_d = HDR_BASE + 8'(own_q);
          last_d    = 1'b0;
          state_d   = START;
        end
      end
`endif

      LOAD: begin
        if (own_valid && !bus.tx_busy) begin
          tx_data_d = own_data;
          last_d    = own_last;
          state_d   = START;
        end else if (!own_valid && TO_EN) begin
          if (cnt_q == TO_LAST) begin
            to_pulse_d = 1'b1;
            grant_d    = '0;
            ptr_d      = own_q;
            cnt_d      = '0;
            state_d    = IDLE;
          end else if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      START: begin
        first_d = 1'b1;
        state_d = BUSY;
      end

      BUSY: begin
        if (!first_q && !bus.tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = own_q;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      own_q      <= '0;
      ptr_q      <= PTR_W'(NREQ - 1);
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      to_pulse_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      own_q      <= own_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      to_pulse_q <= to_pulse_d;
      first_q    <= first_d;
    end
  end

  assign bus.req_ready     = (state_q == LOAD && !bus.tx_busy) ? grant_q : '0;
  assign bus.tx_start      = (state_q == START);
  assign bus.tx_data       = tx_data_q;
  assign bus.grant         = grant_q;
  assign bus.timeout_pulse = to_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT=8). A queue per
//   requester feeds bytes, a transmitter model holds tx_busy for 10 cycles
//   per tx_start, and a monitor logs every started byte with its grant.
//   Define UART_ARB_HDR_EN on both RTL and bench to exercise header bytes.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int         NREQ     = 4;
  localparam int         TIMEOUT  = 8;
  localparam int         CNT_W    = 16;
  localparam logic [7:0] HDR_BASE = 8'hF0;
`ifdef UART_ARB_HDR_EN
  localparam int         HDR_ON   = 1;
`else
  localparam int         HDR_ON   = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .HDR_BASE(HDR_BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for 10 cycles after each start; never reset.
  logic [3:0] tx_cnt = 4'd0;
  always @(posedge clk) begin
    if (bus.tx_start)     tx_cnt <= 4'd10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 4'd1;
  end
  assign bus.tx_busy = (tx_cnt != 4'd0);

  // Requesters: each queue entry is {last, data}; the head is presented.
  logic [8:0]      pq [NREQ][$];
  logic [NREQ-1:0] acc = '0;
  always @(negedge clk) acc = bus.req_valid & bus.req_ready & {NREQ{~reset}};

  task automatic drive_reqs();
    logic [NREQ-1:0]   v;
    logic [NREQ-1:0]   l;
    logic [8*NREQ-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        v[i]         = 1'b1;
        l[i]         = pq[i][0][8];
        d[8*i +: 8]  = pq[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  initial begin
    drive_reqs();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      drive_reqs();
    end
  end

  // Monitor: log started bytes, count handshake rule breaks.
  typedef struct { logic [7:0] data; logic [NREQ-1:0] grant; int cyc; } tx_rec_t;
  typedef struct { logic [7:0] data; logic [NREQ-1:0] grant; } exp_t;
  tx_rec_t log_q [$];
  exp_t    exp_q [$];
  int      viol = 0;

  always @(negedge clk) begin
    if (bus.tx_start) log_q.push_back('{bus.tx_data, bus.grant, cyc});
    if (|(bus.req_ready & ~bus.grant) || $countones(bus.req_ready) > 1 ||
        (|bus.req_ready && bus.tx_busy) || (bus.tx_start && bus.tx_busy))
      viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic send(input int g, input logic [7:0] d, input bit last);
    pq[g].push_back({last, d});
  endtask

  task automatic expect_hdr(input int g);
    if (HDR_ON != 0) exp_q.push_back('{HDR_BASE + 8'(g), onehot(g)});
  endtask

  task automatic expect_byte(input int g, input logic [7:0] d);
    exp_q.push_back('{d, onehot(g)});
  endtask

  task automatic compare_log(input string name);
    check({name, " count"}, log_q.size(), exp_q.size());
    for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
      check($sformatf("%s byte%0d data", name, k), log_q[k].data, exp_q[k].data);
      check($sformatf("%s byte%0d grant", name, k), log_q[k].grant, exp_q[k].grant);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  // Wait until n bytes have started and the grant has been released.
  task automatic wait_done(input string name, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= n && bus.grant == '0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL %s: wait expired, started %0d expected %0d", name, log_q.size(), n);
    end
  endtask

  task automatic wait_starts(input string name, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= n) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL %s: wait expired, started %0d expected %0d", name, log_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [NREQ-1:0] mask;
    int              n;
    int              order [4];
  } rr_vec_t;

  initial begin
    rr_vec_t vec [5];
    int      c0;
    int      drop_cyc;
    int      ready_cnt;
    bit      seen;

    vec[0] = '{4'b1011, 3, '{0, 1, 3, 0}};  // right after reset: 0 first
    vec[1] = '{4'b0011, 2, '{0, 1, 0, 0}};  // ptr at 3 again
    vec[2] = '{4'b0110, 2, '{2, 1, 0, 0}};  // ptr at 1
    vec[3] = '{4'b1001, 2, '{3, 0, 0, 0}};  // ptr at 1, wraps to 0
    vec[4] = '{4'b1111, 4, '{1, 2, 3, 0}};  // ptr at 0

    // ---- reset values ----
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset grant",         bus.grant,         '0);
    check("reset tx_start",      bus.tx_start,      1'b0);
    check("reset tx_data",       bus.tx_data,       8'h00);
    check("reset timeout_pulse", bus.timeout_pulse, 1'b0);
    check("reset req_ready",     bus.req_ready,     '0);
    reset = 1'b0;

    // ---- single 2-byte packet from req0, latency and release timing ----
    @(negedge clk); #1;
    c0 = cyc;
    send(0, 8'h41, 1'b0);
    send(0, 8'h42, 1'b1);
    expect_hdr(0);
    expect_byte(0, 8'h41);
    expect_byte(0, 8'h42);
    wait_done("single", 2 + HDR_ON);
    drop_cyc = cyc;
    if (log_q.size() == 2 + HDR_ON) begin
      check("single first start cycle", log_q[0].cyc, c0 + 3);
      for (int k = 1; k < log_q.size(); k++)
        check($sformatf("single start gap%0d", k), log_q[k].cyc - log_q[k-1].cyc, 13);
      check("single grant release cycle", drop_cyc, log_q[log_q.size()-1].cyc + 12);
    end
    compare_log("single");

    // ---- round-robin vector table, one-byte packets ----
    do_reset();
    for (int v = 0; v < 5; v++) begin
      @(negedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (vec[v].mask[i]) send(i, 8'(8'h10 * (v + 1) + i), 1'b1);
      for (int k = 0; k < vec[v].n; k++) begin
        expect_hdr(vec[v].order[k]);
        expect_byte(vec[v].order[k], 8'(8'h10 * (v + 1) + vec[v].order[k]));
      end
      wait_done($sformatf("rr%0d", v), vec[v].n * (1 + HDR_ON));
      compare_log($sformatf("rr%0d", v));
    end

    // ---- no interleave: req0 3-byte packet while req2 waits ----
    do_reset();
    send(0, 8'hA1, 1'b0);
    send(0, 8'hA2, 1'b0);
    send(0, 8'hA3, 1'b1);
    send(2, 8'hB2, 1'b1);
    expect_hdr(0);
    expect_byte(0, 8'hA1);
    expect_byte(0, 8'hA2);
    expect_byte(0, 8'hA3);
    expect_hdr(2);
    expect_byte(2, 8'hB2);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (bus.req_ready[2]) begin seen = 1'b1; break; end
    end
    check("interleave req2 ready reached", seen, 1'b1);
    check("interleave bytes before req2 ready", log_q.size(), 3 + 2 * HDR_ON);
    check("interleave grant at req2 ready", bus.grant, 4'b0100);
    wait_done("interleave", 4 + 2 * HDR_ON);
    compare_log("interleave");

    // ---- timeout: req1 sends a non-last byte then stalls ----
    do_reset();
    send(1, 8'h77, 1'b0);
    expect_hdr(1);
    expect_byte(1, 8'h77);
    wait_starts("timeout first byte", 1 + HDR_ON);
    seen      = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.timeout_pulse) begin seen = 1'b1; break; end
      if (bus.req_ready[1]) ready_cnt++;
    end
    check("timeout pulse seen", seen, 1'b1);
    check("timeout idle LOAD cycles", ready_cnt, TIMEOUT);
    check("timeout grant cleared", bus.grant, '0);
    compare_log("timeout");
    send(0, 8'hC0, 1'b1);
    send(1, 8'hC1, 1'b1);
    send(2, 8'hC2, 1'b1);
    @(negedge clk); #1;
    check("timeout pulse width", bus.timeout_pulse, 1'b0);
    foreach (vec[0].order[k]) begin end
    expect_hdr(2); expect_byte(2, 8'hC2);
    expect_hdr(0); expect_byte(0, 8'hC0);
    expect_hdr(1); expect_byte(1, 8'hC1);
    wait_done("after timeout", 3 * (1 + HDR_ON));
    compare_log("after timeout");

    // ---- reset during BUSY ----
    send(1, 8'h66, 1'b1);
    expect_hdr(1);
    expect_byte(1, 8'h66);
    wait_starts("midreset start", 1 + HDR_ON);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("midreset grant",     bus.grant,     '0);
    check("midreset tx_start",  bus.tx_start,  1'b0);
    check("midreset req_ready", bus.req_ready, '0);
    compare_log("midreset");
    send(0, 8'hD0, 1'b1);
    send(1, 8'hD1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("postreset grant", bus.grant, 4'b0001);
    check("postreset ready held while busy", bus.req_ready, '0);
    expect_hdr(0); expect_byte(0, 8'hD0);
    expect_hdr(1); expect_byte(1, 8'hD1);
    wait_done("postreset", 2 * (1 + HDR_ON));
    compare_log("postreset");

    // ---- single-byte packet from req2 ----
    send(2, 8'h55, 1'b1);
    expect_hdr(2);
    expect_byte(2, 8'h55);
    wait_done("single byte", 1 + HDR_ON);
    compare_log("single byte");

    check("handshake violations", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one async_transmitter between NREQ byte-stream requesters, with round-robin, packet-granular arbitration.
- A grant is held from the first byte of a packet until its byte flagged last has finished transmitting, so packets never interleave on TxD.
- Sits between the host-side producers (status, debug and data channels) and the transmitter's TxD_start/TxD_data/TxD_busy interface.
- Releases a stalled owner after a programmable timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, cycles the owner may leave req_valid low in LOAD before the grant is revoked; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; TIMEOUT must be < 2**CNT_W.
- HDR_BASE, 8'hF0, header byte base value (used only with the optional feature).

Ports:
- clk, in, 1, the block's single clock.
- reset, in, 1, synchronous, active-high reset.
- req_valid, in, NREQ, per-requester byte valid.
- req_data, in, 8*NREQ, byte for requester i in bits [8i+7:8i].
- req_last, in, NREQ, marks the final byte of a packet; sampled together with req_data.
- req_ready, out, NREQ, byte accepted in this cycle (combinational).
- tx_start, out, 1, one-cycle pulse to the transmitter's TxD_start.
- tx_data, out, 8, registered byte to the transmitter's TxD_data.
- tx_busy, in, 1, from the transmitter's TxD_busy.
- grant, out, NREQ, registered one-hot owner; all zero when there is no owner.
- timeout_pulse, out, 1, one-cycle flag when a grant is revoked by timeout.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on port reset, and dominates all other logic.
- Reset values:
  - state = IDLE; grant = 0; tx_start = 0; tx_data = 0; timeout_pulse = 0.
  - Round-robin pointer ptr = NREQ-1, so requester 0 wins first.
  - req_ready = 0.
- Reset mid-packet:
  - The packet is abandoned. The transmitter is not reset, so a byte already in flight completes.
  - The next LOAD waits for tx_busy = 0 before accepting a byte.
- IDLE:
  - If any req_valid bit is set, grant the first requester i with req_valid[i]=1, searching ptr+1, ptr+2, ... modulo NREQ.
  - Register grant and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - req_ready[g] = (state==LOAD) & grant[g] & ~tx_busy. All other req_ready bits are 0.
  - On req_valid[g] & req_ready[g]: latch req_data into tx_data, latch req_last into last_q, and go to START.
- LOAD timeout:
  - The counter clears on entry to LOAD and increments each LOAD cycle with req_valid[g]=0.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): pulse timeout_pulse, clear grant, set ptr = g, go to IDLE.
- START:
  - tx_start = 1 for exactly one cycle, then go to BUSY.
- BUSY:
  - The first BUSY cycle ignores tx_busy, which rises one cycle after tx_start.
  - On later cycles, when tx_busy = 0: if last_q = 1, clear grant, set ptr = g, go to IDLE. Otherwise go to LOAD.
- Latency:
  - req_valid seen in IDLE → byte accepted in the next cycle → tx_start one cycle after that (2 cycles from IDLE).
  - Back-to-back bytes within a packet: tx_busy falling → LOAD → START costs 2 extra cycles.
- Simultaneous requests: only the owner's req_ready can be high. Non-owners hold their data until granted.
- Width rules:
  - ptr is clog2(NREQ) bits and wraps modulo NREQ.
  - The timeout counter saturates at TIMEOUT.
- Single-byte packet (req_last on the first byte): the grant is released after that byte.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- When defined:
  - After a grant is registered in IDLE, the block first goes to HDR, which loads tx_data = HDR_BASE + g (8-bit wrap), then to START and BUSY. It then returns to LOAD for payload bytes.
  - The header byte has last_q forced to 0.
  - The timeout applies only in LOAD.
- When undefined: the HDR state is absent, and IDLE goes directly to LOAD.

Test Plan:
- Single packet: req0 sends 0x41, 0x42(last) with a transmitter model asserting busy for 10 cycles → tx_data 0x41 then 0x42; tx_start first asserted 2 cycles after req_valid; grant 4'b0001 throughout, 0 after the second byte completes.
- Round robin: req0, req1 and req3 all hold 1-byte packets after reset → packets are transmitted in the order 0, 1, 3. Then req0 and req1 post again → 0, then 1.
- No interleave: req0 sends a 3-byte packet while req2 is valid → req_ready[2] stays 0 until req0's last byte completes; then grant = 4'b0100.
- Timeout: TIMEOUT=8; req1 sends a first byte (not last) then drops valid → timeout_pulse is seen 8 LOAD cycles later; grant = 0; the next grant searches from 2.
- Reset: assert reset during BUSY → next cycle grant = 0, tx_start = 0, state IDLE; req0 is granted first after reset.
- With UART_ARB_HDR_EN: req2 sends 0x55(last) → transmitted bytes are 0xF2 then 0x55.
